// File: rtl/mux_scan.sv
// rtl/mux_scan.sv - registered N-channel multi-bit mux with manual and auto-scan channel selection
//
// Purpose: selects one of CH input lanes (W bits each) onto a registered output
// tagged with its source channel. MANUAL mode takes a load-strobed channel
// request; SCAN mode steps through channels, holding each for DWELL enabled cycles.
//
// Optional feature: define MUX_SCAN_SKIP_EN to add skip_mask, which lets SCAN
// mode bypass selected channels.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   x         channel inputs, channel k at x[k*W +: W]
//   sel       manual channel request
//   load      apply sel at this edge (MANUAL only)
//   mode      0 = MANUAL, 1 = SCAN
//   skip_mask (MUX_SCAN_SKIP_EN only) 1 = skip channel in SCAN
//   en        global enable; 0 freezes all state
//   y         registered selected data
//   y_ch      channel index y was sampled from
//   cur       currently selected channel
//   wrap      one-cycle pulse when the scan wraps around
module mux_scan #(
  parameter int CH    = 4,
  parameter int W     = 1,
  parameter int DWELL = 4,
  localparam int SELW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CH*W-1:0] x,
  input  logic [SELW-1:0] sel,
  input  logic            load,
  input  logic            mode,
`ifdef MUX_SCAN_SKIP_EN
  input  logic [CH-1:0]   skip_mask,
`endif
  input  logic            en,
  output logic [W-1:0]    y,
  output logic [SELW-1:0] y_ch,
  output logic [SELW-1:0] cur,
  output logic            wrap
);

  localparam int CW = $clog2(DWELL) + 1;

  typedef enum logic {
    MANUAL = 1'b0,
    SCAN   = 1'b1
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [SELW-1:0] nxt;
  logic            has_next;
  logic            last;
  logic            sel_ok;

  assign last = (cnt == CW'(DWELL - 1));

  // Requests beyond the last channel can only occur for non-power-of-two CH.
  assign sel_ok = (32'(sel) < CH);

`ifdef MUX_SCAN_SKIP_EN
  // Cyclic search for the nearest unmasked channel after cur. Distance CH lands
  // back on cur itself, so a lone unmasked cur keeps being revisited. The sum
  // cur+d stays below 2*CH, so a single conditional subtract wraps it.
  logic [SELW:0] idx;
  always_comb begin
    nxt      = cur;
    has_next = 1'b0;
    idx      = '0;
    for (int d = 1; d <= CH; d++) begin
      idx = {1'b0, cur} + (SELW+1)'(d);
      if (idx >= (SELW+1)'(CH))
        idx = idx - (SELW+1)'(CH);
      if (!has_next && !skip_mask[idx[SELW-1:0]]) begin
        nxt      = idx[SELW-1:0];
        has_next = 1'b1;
      end
    end
  end
`else
  // Explicit wrap at CH-1 so non-power-of-two CH never reaches a dead index.
  always_comb begin
    has_next = 1'b1;
    if (cur == SELW'(CH - 1))
      nxt = '0;
    else
      nxt = cur + 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= MANUAL;
      cur   <= '0;
      cnt   <= '0;
      y     <= '0;
      y_ch  <= '0;
      wrap  <= 1'b0;
    end else if (en) begin
      // Data path always samples the pre-edge channel, so y_ch trails cur by one edge.
      y    <= x[cur*W +: W];
      y_ch <= cur;
      if (state == MANUAL && mode) begin
        // Entering scan: the current channel gets a full dwell first.
        state <= SCAN;
        cnt   <= '0;
        wrap  <= 1'b0;
      end else if (state == SCAN && !mode) begin
        state <= MANUAL;
        cnt   <= '0;
        wrap  <= 1'b0;
      end else if (state == SCAN) begin
        if (last) begin
          cnt  <= '0;
          cur  <= nxt;
          // With every channel masked nothing moves and no wrap is reported.
          wrap <= has_next && (nxt <= cur);
        end else begin
          cnt  <= cnt + 1'b1;
          wrap <= 1'b0;
        end
      end else begin
        if (load && sel_ok)
          cur <= sel;
        wrap <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule
